// File: rtl/multiplier_ctrl_if.sv
// Booth multiplier controller <-> datapath bundle: start request, Booth pair, strobes, status.
// Pure wiring, no latency of its own.
// Optional MULT_CTRL_DONE_HOLD_EN adds done_ack so a consumer can hold the result in DONE.
interface multiplier_ctrl_if #(
  parameter int ITER = 8
);
  localparam int IW = $clog2(ITER);

  logic          start;
  logic [1:0]    Qo_Qprev;
  logic          load_M;
  logic          load_Q;
  logic          reset_A;
  logic          reset_Qprev;
  logic          add_M;
  logic          subs_M;
  logic          shift_all;
  logic          ready;
  logic          busy;
  logic          done;
  logic [IW-1:0] iter;
`ifdef MULT_CTRL_DONE_HOLD_EN
  logic          done_ack;
`endif

  // Controller side: consumes the request and Booth pair, drives strobes and status.
`ifdef MULT_CTRL_DONE_HOLD_EN
  modport master (
    input  start, Qo_Qprev, done_ack,
    output load_M, load_Q, reset_A, reset_Qprev, add_M, subs_M, shift_all,
           ready, busy, done, iter
  );
  modport slave (
    output start, Qo_Qprev, done_ack,
    input  load_M, load_Q, reset_A, reset_Qprev, add_M, subs_M, shift_all,
           ready, busy, done, iter
  );
`else
  modport master (
    input  start, Qo_Qprev,
    output load_M, load_Q, reset_A, reset_Qprev, add_M, subs_M, shift_all,
           ready, busy, done, iter
  );
  modport slave (
    output start, Qo_Qprev,
    input  load_M, load_Q, reset_A, reset_Qprev, add_M, subs_M, shift_all,
           ready, busy, done, iter
  );
`endif
endinterface

// File: rtl/multiplier_ctrl.sv
// Moore FSM sequencing a radix-2 Booth datapath: LOAD, then EVAL/[ADD|SUB]/SHIFT per iteration, then DONE.
// Latency: 1 + 2*ITER + (ADD/SUB visits) cycles from the accepting edge to done.
// start is only accepted in IDLE; DONE waits for done_ack when MULT_CTRL_DONE_HOLD_EN is defined, else pulses once.
module multiplier_ctrl #(
  parameter int ITER = 8
) (
  input logic              clk,
  input logic              reset,
  multiplier_ctrl_if.master bus
);

  localparam int            IW   = $clog2(ITER);
  localparam logic [IW-1:0] LAST = IW'(ITER - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    EVAL  = 3'd2,
    ADD   = 3'd3,
    SUB   = 3'd4,
    SHIFT = 3'd5,
    DONE  = 3'd6
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] iter_q, iter_d;

  // State and iteration counter; reset forces IDLE and clears the count.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      iter_q  <= '0;
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
    end
  end

  // Next state and counter; the Booth pair only matters in EVAL.
  always_comb begin
    state_d = state_q;
    iter_d  = iter_q;
    case (state_q)
      IDLE: begin
        if (bus.start) state_d = LOAD;
      end
      LOAD: begin
        iter_d  = '0;
        state_d = EVAL;
      end
      EVAL: begin
        case (bus.Qo_Qprev)
          2'b01:   state_d = ADD;
          2'b10:   state_d = SUB;
          default: state_d = SHIFT;
        endcase
      end
      ADD:  state_d = SHIFT;
      SUB:  state_d = SHIFT;
      SHIFT: begin
        // Counter stops at ITER-1 so it reads the final index while in DONE.
        if (iter_q == LAST) begin
          state_d = DONE;
        end else begin
          iter_d  = iter_q + IW'(1);
          state_d = EVAL;
        end
      end
      DONE: begin
`ifdef MULT_CTRL_DONE_HOLD_EN
        if (bus.done_ack) state_d = IDLE;
`else
        state_d = IDLE;
`endif
      end
      default: begin
        // Unused encoding: recover to IDLE with a clean counter.
        state_d = IDLE;
        iter_d  = '0;
      end
    endcase
  end

  // Moore output decode straight from the state register.
  always_comb begin
    bus.load_M      = 1'b0;
    bus.load_Q      = 1'b0;
    bus.reset_A     = 1'b0;
    bus.reset_Qprev = 1'b0;
    bus.add_M       = 1'b0;
    bus.subs_M      = 1'b0;
    bus.shift_all   = 1'b0;
    bus.ready       = 1'b0;
    bus.busy        = 1'b0;
    bus.done        = 1'b0;
    case (state_q)
      IDLE: bus.ready = 1'b1;
      LOAD: begin
        bus.load_M      = 1'b1;
        bus.load_Q      = 1'b1;
        bus.reset_A     = 1'b1;
        bus.reset_Qprev = 1'b1;
        bus.busy        = 1'b1;
      end
      EVAL: bus.busy = 1'b1;
      ADD: begin
        bus.add_M = 1'b1;
        bus.busy  = 1'b1;
      end
      SUB: begin
        bus.subs_M = 1'b1;
        bus.busy   = 1'b1;
      end
      SHIFT: begin
        bus.shift_all = 1'b1;
        bus.busy      = 1'b1;
      end
      DONE:    bus.done = 1'b1;
      default: ;
    endcase
  end

  assign bus.iter = iter_q;

endmodule

// File: doc/multiplier_ctrl.md
MULTIPLIER_CTRL -- requirements
Module: multiplier_ctrl

Interface
REQ-001 SHALL provide parameter ITER, default 8, meaning the number of Booth iterations per multiplication (equal to the operand width).
REQ-002 SHALL provide port clk, input, 1, the single clock; all state changes on rising edge.
REQ-003 SHALL provide port reset, input, 1, synchronous active-low reset.
REQ-004 SHALL provide port start, input, 1, request to begin one multiplication; sampled only while ready=1.
REQ-005 SHALL provide port Qo_Qprev, input, 2, datapath Booth pair {Q[0], Q_prev}.
REQ-006 SHALL provide ports load_M and load_Q, each output, 1, datapath operand load strobes.
REQ-007 SHALL provide ports reset_A and reset_Qprev, each output, 1, datapath accumulator and Q_prev clear strobes.
REQ-008 SHALL provide ports add_M, subs_M and shift_all, each output, 1, datapath A+M, A-M and arithmetic-shift strobes.
REQ-009 SHALL provide port ready, output, 1, high only in IDLE.
REQ-010 SHALL provide port busy, output, 1, high in every state except IDLE and DONE.
REQ-011 SHALL provide port done, output, 1, result-valid indication; mult_result is stable while done=1.
REQ-012 SHALL provide port iter, output, $clog2(ITER), the current iteration index.

Function
REQ-013 SHALL be a Moore FSM with states IDLE, LOAD, EVAL, ADD, SUB, SHIFT and DONE; every output SHALL decode from the state register only.
REQ-014 IDLE: ready=1; start=1 at a rising edge SHALL move the FSM to LOAD; otherwise it SHALL stay in IDLE.
REQ-015 LOAD: load_M, load_Q, reset_A and reset_Qprev SHALL all be high for exactly one cycle; iter SHALL clear to 0; next state is EVAL.
REQ-016 EVAL: no strobe is high; Qo_Qprev=01 SHALL go to ADD, 10 to SUB, and 00 or 11 directly to SHIFT.
REQ-017 ADD SHALL assert add_M for one cycle, then go to SHIFT.
REQ-018 SUB SHALL assert subs_M for one cycle, then go to SHIFT.
REQ-019 SHIFT SHALL assert shift_all for one cycle; if iter=ITER-1 it SHALL go to DONE, else it SHALL increment iter and go to EVAL.
REQ-020 At most one of add_M, subs_M and shift_all SHALL be high in any cycle.
REQ-021 Qo_Qprev SHALL be ignored in every state except EVAL.
REQ-022 start SHALL be ignored outside IDLE; a held start SHALL re-launch only after return to IDLE.
REQ-023 Latency from the accepting edge to done=1 SHALL be 1 + 2*ITER + (number of ADD/SUB visits) cycles: 17 minimum and 25 maximum for ITER=8.
REQ-024 Any unreachable state encoding SHALL return the FSM to IDLE on the next edge with all strobes low.
REQ-025 The iteration counter SHALL NOT wrap during an operation; iter SHALL hold ITER-1 in DONE.

Reset
REQ-026 With reset=0 at a rising edge, the FSM SHALL enter IDLE and iter SHALL become 0.
REQ-027 During reset, all strobes, busy and done SHALL be 0, and ready SHALL be 1 from the first edge after reset releases.
REQ-028 Reset asserted mid-operation SHALL abort the operation with no further strobes; the datapath contents are don't-care.

Configuration
REQ-029 With MULT_CTRL_DONE_HOLD_EN defined, the block SHALL add input done_ack (1 bit), hold DONE with done=1 until done_ack=1 at an edge, and then go to IDLE.
REQ-030 Without MULT_CTRL_DONE_HOLD_EN, done_ack SHALL be absent, and DONE SHALL last exactly one cycle (done pulse) before returning to IDLE.

Verification
REQ-031 15 x 5 (Q=00000101): start pulse -> strobe order LOAD, SUB, SHIFT, ADD, SHIFT, SUB, SHIFT, ADD, SHIFT, then 4x SHIFT-only; done 21 cycles after accept; product 75 (0x004B).
REQ-032 Q=0 (Qo_Qprev always 00) -> no add_M/subs_M; done after 17 cycles; product 0.
REQ-033 Q=0x55 with M=3 -> ADD or SUB every iteration; done after 25 cycles; product 255.
REQ-034 start held high throughout -> no extra LOAD while busy; second LOAD only after done and IDLE.
REQ-035 reset=0 on the cycle after the 3rd SHIFT -> next cycle: IDLE, all strobes 0, iter=0, ready=1; fresh 15 x 5 after release -> 75.
REQ-036 MULT_CTRL_DONE_HOLD_EN build: done_ack held low for 10 cycles -> done stays 1 and start is ignored; done_ack=1 -> IDLE on the next edge.
